// File: rtl/test_ctrl_pkg.sv
// Shared types and default widths for the test run controller.
//   state_e  : run sequencer states
//   reason_e : verdict code reported on the reason output
package test_ctrl_pkg;

    localparam int CNT_W_DEF = 64;
    localparam int RST_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RSN_NONE     = 2'd0,
        RSN_PASS     = 2'd1,
        RSN_DUT_FAIL = 2'd2,
        RSN_TIMEOUT  = 2'd3
    } reason_e;

    function automatic logic is_verdict(input state_e s);
        return (s == ST_PASS) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/test_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : load zero (wins over en)
//   en             : advance by one, holding at all-ones
//   q              : registered count
//   nxt            : value q takes on the next edge
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = q;
        if (clear)
            nxt = '0;
        else if (en && (q != {W{1'b1}}))
            nxt = q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            q <= '0;
        else
            q <= nxt;
    end

endmodule

// File: rtl/test_run_controller.sv
// Run sequencer between the simulation top and the test harness: owns the
// harness reset, counts run cycles, opens the dump window, runs the cycle
// budget watchdog and latches a pass/fail verdict with a reason code.
//   clock, reset_n   : clock and synchronous active-low reset
//   start            : pulse, begins a run from IDLE/PASS/FAIL
//   cfg_*            : run configuration, captured when start is accepted
//   dut_success/fail : harness verdict inputs, only looked at in RUN
//   dut_reset        : active-high harness reset
//   dump_en          : waveform dump enable
//   done/passed/failed/reason : latched verdict
//   cycle_count      : cycles since start was accepted (saturating)
module test_run_controller
    import test_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RST_W = RST_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_max_cycles,
    input  logic [CNT_W-1:0] cfg_dump_start,
    input  logic [RST_W-1:0] cfg_reset_cycles,
    input  logic             dut_success,
    input  logic             dut_failure,
    output logic             dut_reset,
    output logic             dump_en,
    output logic             done,
    output logic             passed,
    output logic             failed,
    output logic [1:0]       reason,
    output logic [CNT_W-1:0] cycle_count
);

    state_e           state, state_n;
    reason_e          reason_q, reason_n;
    logic [CNT_W-1:0] max_cfg, dump_cfg;
    logic [RST_W-1:0] rst_cfg, rst_len;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RST_W-1:0] hold_q, hold_nxt;
    logic             accept, wd_hit, hold_done, cnt_en, dump_n;

    assign accept  = start && ((state == ST_IDLE) || is_verdict(state));
    assign rst_len = (rst_cfg == '0) ? {{(RST_W-1){1'b0}}, 1'b1} : rst_cfg;
    // hold_nxt is hold_q+1 while holding, so this fires on the last hold cycle
    assign hold_done = (hold_nxt == rst_len);
    // Watchdog compares the count before this edge's increment
    assign wd_hit  = (max_cfg != '0) && (cycle_count >= max_cfg);
    // A timeout edge does not advance the count, so it freezes at the budget
    assign cnt_en  = (state == ST_RESET_HOLD) ||
                     ((state == ST_RUN) && (dut_failure || !wd_hit));

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .en      (cnt_en),
        .q       (cycle_count),
        .nxt     (cnt_nxt)
    );

    sat_counter #(.W(RST_W)) u_hold_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .en      (state == ST_RESET_HOLD),
        .q       (hold_q),
        .nxt     (hold_nxt)
    );

    always_comb begin
        state_n  = state;
        reason_n = reason_q;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_RESET_HOLD;
            end
            ST_RESET_HOLD: begin
                if (hold_done) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (dut_failure) begin
                    state_n  = ST_FAIL;
                    reason_n = RSN_DUT_FAIL;
                end else if (wd_hit) begin
                    state_n  = ST_FAIL;
                    reason_n = RSN_TIMEOUT;
                end else if (dut_success) begin
                    state_n  = ST_PASS;
                    reason_n = RSN_PASS;
                end
            end
            ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_n  = ST_RESET_HOLD;
                    reason_n = RSN_NONE;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                reason_n = RSN_NONE;
            end
        endcase
    end

    // Dump enable is registered against the count it will be paired with,
    // so it is high in the very cycle cycle_count equals the start point.
    always_comb begin
        dump_n = dump_en;
        if (accept)
            dump_n = (cfg_dump_start == '0);
        else if (is_verdict(state_n))
            dump_n = 1'b0;
        else if ((state == ST_RESET_HOLD) || (state == ST_RUN))
            dump_n = dump_en || (cnt_nxt == dump_cfg);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            reason_q  <= RSN_NONE;
            max_cfg   <= '0;
            dump_cfg  <= '0;
            rst_cfg   <= '0;
            dut_reset <= 1'b1;
            dump_en   <= 1'b0;
            done      <= 1'b0;
            passed    <= 1'b0;
            failed    <= 1'b0;
        end else begin
            state     <= state_n;
            reason_q  <= reason_n;
            if (accept) begin
                max_cfg  <= cfg_max_cycles;
                dump_cfg <= cfg_dump_start;
                rst_cfg  <= cfg_reset_cycles;
            end
            dut_reset <= (state_n == ST_IDLE) || (state_n == ST_RESET_HOLD);
            dump_en   <= dump_n;
            done      <= is_verdict(state_n);
            passed    <= (state_n == ST_PASS);
            failed    <= (state_n == ST_FAIL);
        end
    end

    assign reason = reason_q;

endmodule

// File: tb/tb_test_run_controller.sv
// Scoreboard bench for test_run_controller: stimulus pushes expected events
// (harness reset release count, dump rise count, verdict) into queues and a
// negedge monitor pops and compares whenever the DUT produces that event.
module tb_test_run_controller;

    localparam int CW = 64;
    localparam int RW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          dut_success = 1'b0;
    logic          dut_failure = 1'b0;
    logic [CW-1:0] cfg_max_cycles = '0;
    logic [CW-1:0] cfg_dump_start = '0;
    logic [RW-1:0] cfg_reset_cycles = '0;
    logic          dut_reset, dump_en, done, passed, failed;
    logic [1:0]    reason;
    logic [CW-1:0] cycle_count;

    test_run_controller #(.CNT_W(CW), .RST_W(RW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .cfg_max_cycles   (cfg_max_cycles),
        .cfg_dump_start   (cfg_dump_start),
        .cfg_reset_cycles (cfg_reset_cycles),
        .dut_success      (dut_success),
        .dut_failure      (dut_failure),
        .dut_reset        (dut_reset),
        .dump_en          (dump_en),
        .done             (done),
        .passed           (passed),
        .failed           (failed),
        .reason           (reason),
        .cycle_count      (cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        passed;
        logic        failed;
        logic [1:0]  reason;
        logic [63:0] cnt;
    } verdict_t;

    verdict_t    vq[$];
    logic [63:0] rq[$];
    logic [63:0] dq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic        p_done, p_dump, p_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected or not seen (count %0d)", name, cycle_count);
    endtask

    // Monitor: compares every DUT event against the head of its queue
    always @(negedge clock) begin : monitor
        verdict_t e;
        if (mon_en) begin
            if (p_rst === 1'b1 && dut_reset === 1'b0) begin
                if (rq.size() == 0) miss("rst_fall");
                else chk("rst_fall_count", cycle_count, rq.pop_front());
            end
            if (p_dump === 1'b0 && dump_en === 1'b1) begin
                if (dq.size() == 0) miss("dump_rise");
                else chk("dump_rise_count", cycle_count, dq.pop_front());
            end
            if (p_done === 1'b0 && done === 1'b1) begin
                if (vq.size() == 0) miss("verdict");
                else begin
                    e = vq.pop_front();
                    chk("verdict_passed", 64'(passed), 64'(e.passed));
                    chk("verdict_failed", 64'(failed), 64'(e.failed));
                    chk("verdict_reason", 64'(reason), 64'(e.reason));
                    chk("verdict_count", cycle_count, e.cnt);
                    chk("verdict_dump_off", 64'(dump_en), 64'd0);
                end
            end
        end
        p_done = done;
        p_dump = dump_en;
        p_rst  = dut_reset;
    end

    task automatic do_start(input int rc, input int mx, input int ds);
        cfg_reset_cycles = RW'(rc);
        cfg_max_cycles   = CW'(mx);
        cfg_dump_start   = CW'(ds);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        // Scramble config so a DUT using live config instead of captured copies shows up
        cfg_reset_cycles = 16'd9;
        cfg_max_cycles   = 64'd3;
        cfg_dump_start   = 64'd5;
    endtask

    task automatic wait_count(input int target);
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (cycle_count === CW'(target)) return;
        end
        miss("wait_count_timeout");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) return;
            @(negedge clock);
        end
        miss("wait_done_timeout");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_reset"}, 64'(dut_reset), 64'd1);
        chk({tag, "_dump_en"},   64'(dump_en),   64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_passed"},    64'(passed),    64'd0);
        chk({tag, "_failed"},    64'(failed),    64'd0);
        chk({tag, "_reason"},    64'(reason),    64'd0);
        chk({tag, "_count"},     cycle_count,    64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        mon_en  = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_holds_reset", 64'(dut_reset), 64'd1);

        // Reset hold 4, no watchdog, dump at 7, pass at count 10
        rq.push_back(64'd4);
        dq.push_back(64'd7);
        vq.push_back('{1'b1, 1'b0, 2'd1, 64'd11});
        do_start(4, 0, 7);
        wait_count(1);
        dut_success = 1'b1;
        @(negedge clock);
        dut_success = 1'b0;
        chk("hold_ignores_success_rst", 64'(dut_reset), 64'd1);
        chk("hold_ignores_success_done", 64'(done), 64'd0);
        wait_count(8);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_in_run_ignored", cycle_count, 64'd9);
        wait_count(10);
        dut_success = 1'b1;
        @(negedge clock);
        dut_success = 1'b0;
        repeat (3) @(negedge clock);
        chk("pass_count_frozen", cycle_count, 64'd11);
        chk("pass_done_held", 64'(done), 64'd1);
        chk("pass_rst_low", 64'(dut_reset), 64'd0);

        // Restart from PASS: reset hold 0 (as 1), watchdog 20, dump from first cycle
        dq.push_back(64'd0);
        rq.push_back(64'd1);
        vq.push_back('{1'b0, 1'b1, 2'd3, 64'd20});
        do_start(0, 20, 0);
        chk("restart_count", cycle_count, 64'd0);
        chk("restart_reason", 64'(reason), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_rst", 64'(dut_reset), 64'd1);
        wait_done();

        // Failure and success together
        rq.push_back(64'd2);
        vq.push_back('{1'b0, 1'b1, 2'd2, 64'd6});
        do_start(2, 0, 1000);
        wait_count(5);
        dut_failure = 1'b1;
        dut_success = 1'b1;
        @(negedge clock);
        dut_failure = 1'b0;
        dut_success = 1'b0;
        wait_done();

        // Timeout together with success at the exact budget
        rq.push_back(64'd3);
        vq.push_back('{1'b0, 1'b1, 2'd3, 64'd8});
        do_start(3, 8, 1000);
        wait_count(8);
        dut_success = 1'b1;
        @(negedge clock);
        dut_success = 1'b0;
        wait_done();

        // Reset in the middle of a run
        rq.push_back(64'd4);
        do_start(4, 0, 1000);
        wait_count(50);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk_reset_vals("midrun");

        // Normal run after the mid-run reset
        rq.push_back(64'd1);
        dq.push_back(64'd3);
        vq.push_back('{1'b1, 1'b0, 2'd1, 64'd6});
        do_start(1, 0, 3);
        wait_count(5);
        dut_success = 1'b1;
        @(negedge clock);
        dut_success = 1'b0;
        wait_done();
        repeat (2) @(negedge clock);

        chk("rst_queue_drained", 64'(rq.size()), 64'd0);
        chk("dump_queue_drained", 64'(dq.size()), 64'd0);
        chk("verdict_queue_drained", 64'(vq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
